// File: rtl/yapp_router_n_pkg.sv
// +--------------------------------------------------------------------------+
// | yapp_router_n_pkg : FSM states, HBUS register map and reset values       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package yapp_router_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2,
    ST_DROP    = 2'd3
  } state_t;

  localparam logic [7:0] c_reg_maxpktsize = 8'h00;
  localparam logic [7:0] c_reg_router_en  = 8'h01;
  localparam logic [7:0] c_reg_drop_cnt   = 8'h02;
  localparam logic [7:0] c_reg_perr_cnt   = 8'h03;

  localparam logic [7:0] MAXPKTSIZE_RST = 8'h3F;
  localparam logic       ROUTER_EN_RST  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/yapp_fifo.sv
// +--------------------------------------------------------------------------+
// | yapp_fifo : synchronous first-word-fall-through FIFO with full/empty     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module yapp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int              c_aw      = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_depth   = (c_aw+1)'(DEPTH);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw-1:0]  r_wr_ptr;
  logic [c_aw-1:0]  r_rd_ptr;
  logic [c_aw:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_count == c_depth);
  assign empty   = (r_count == '0);
  assign w_push  = push & ~full;
  assign w_pop   = pop & ~empty;
  // Head is forced to zero while empty so the output bus is quiet when invalid
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_push && !w_pop)      r_count <= r_count + c_cnt_one;
      else if (!w_push && w_pop) r_count <= r_count - c_cnt_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/yapp_router_n.sv
// +--------------------------------------------------------------------------+
// | yapp_router_n : YAPP packet router to NUM_CH FIFOs, HBUS configuration.  |
// | YAPP_ROUTER_N_STATS_EN adds drop / parity-error counters. Revision 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module yapp_router_n #(
  parameter int NUM_CH     = 3,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_data_vld,
  output logic                     in_suspend,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        data_vld,
  input  logic [NUM_CH-1:0]        suspend,
  input  logic [7:0]               haddr,
  input  logic [7:0]               hdata_w,
  output logic [7:0]               hdata_r,
  input  logic                     hen,
  input  logic                     hwr_rd,
  output logic                     error
);
  import yapp_router_n_pkg::*;

  localparam int                c_len_w   = DATA_W - ADDR_W;
  localparam logic [ADDR_W:0]   c_num_ch  = (ADDR_W+1)'(NUM_CH);
  localparam logic [c_len_w:0]  c_cnt_one = (c_len_w+1)'(1);

  state_t              r_state, w_state_nxt;
  logic [c_len_w:0]    r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_xor;
  logic [7:0]          r_maxpktsize;
  logic                r_router_en;
  logic                r_error;
  logic [7:0]          r_hdata_r;
  logic [7:0]          w_rd_mux;
  logic [NUM_CH-1:0]   w_full, w_empty, w_push, w_pop, w_sel;
  logic [ADDR_W-1:0]   w_hdr_addr, w_wr_addr;
  logic [c_len_w-1:0]  w_hdr_len;
  logic                w_accept, w_legal, w_wr_en, w_drop_inc, w_par_err;

  assign w_hdr_addr = in_data[ADDR_W-1:0];
  assign w_hdr_len  = in_data[DATA_W-1:ADDR_W];
  assign w_accept   = in_data_vld & ~in_suspend;
  assign w_legal    = r_router_en & ({1'b0, w_hdr_addr} < c_num_ch)
                    & ({8'b0, w_hdr_len} <= {{c_len_w{1'b0}}, r_maxpktsize});
  assign w_wr_addr  = (r_state == ST_IDLE) ? w_hdr_addr : r_addr;
  assign error      = r_error;
  assign hdata_r    = r_hdata_r;

  always_comb begin
    in_suspend = 1'b1;
    if (reset) begin
      case (r_state)
        ST_IDLE:               in_suspend = |w_full;
        ST_PAYLOAD, ST_PARITY: in_suspend = |(w_full & w_sel);
        default:               in_suspend = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_drop_inc  = 1'b0;
    w_par_err   = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          if (w_legal) begin
            w_wr_en     = 1'b1;
            w_cnt_nxt   = {1'b0, w_hdr_len};
            w_state_nxt = (w_hdr_len == '0) ? ST_PARITY : ST_PAYLOAD;
          end else begin
            // Drop covers the payload plus the trailing parity byte
            w_drop_inc  = 1'b1;
            w_cnt_nxt   = {1'b0, w_hdr_len} + c_cnt_one;
            w_state_nxt = ST_DROP;
          end
        end
        ST_PAYLOAD: begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: begin
          w_wr_en     = 1'b1;
          w_par_err   = ((r_xor ^ in_data) != '0);
          w_state_nxt = ST_IDLE;
        end
        default: begin
          w_cnt_nxt = r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_xor   <= '0;
      r_error <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_error <= w_par_err;
      if (w_accept) begin
        if (r_state == ST_IDLE) begin
          r_addr <= w_hdr_addr;
          r_xor  <= in_data;
        end else begin
          r_xor  <= r_xor ^ in_data;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_sel[i]    = (r_addr == ADDR_W'(i));
    assign w_push[i]   = w_wr_en & (w_wr_addr == ADDR_W'(i));
    assign w_pop[i]    = ~w_empty[i] & ~suspend[i];
    assign data_vld[i] = ~w_empty[i];

    yapp_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (w_push[i]),
      .wr_data (in_data),
      .pop     (w_pop[i]),
      .rd_data (data[i*DATA_W +: DATA_W]),
      .full    (w_full[i]),
      .empty   (w_empty[i])
    );
  end

`ifdef YAPP_ROUTER_N_STATS_EN
  logic [7:0] r_drop_cnt, r_perr_cnt;
  logic       w_drop_clr, w_perr_clr;

  assign w_drop_clr = hen & hwr_rd & (haddr == c_reg_drop_cnt);
  assign w_perr_clr = hen & hwr_rd & (haddr == c_reg_perr_cnt);

  // Saturating counters; a software clear beats a same-cycle increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_drop_cnt <= '0;
      r_perr_cnt <= '0;
    end else begin
      if (w_drop_clr)                             r_drop_cnt <= '0;
      else if (w_drop_inc && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_perr_clr)                             r_perr_cnt <= '0;
      else if (w_par_err && r_perr_cnt != 8'hFF)  r_perr_cnt <= r_perr_cnt + 8'd1;
    end
  end
`else
  logic w_unused_stats;
  assign w_unused_stats = w_drop_inc;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (haddr)
      c_reg_maxpktsize: w_rd_mux = r_maxpktsize;
      c_reg_router_en:  w_rd_mux = {7'b0, r_router_en};
`ifdef YAPP_ROUTER_N_STATS_EN
      c_reg_drop_cnt:   w_rd_mux = r_drop_cnt;
      c_reg_perr_cnt:   w_rd_mux = r_perr_cnt;
`endif
      default:          w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_maxpktsize <= MAXPKTSIZE_RST;
      r_router_en  <= ROUTER_EN_RST;
      r_hdata_r    <= '0;
    end else begin
      if (hen && hwr_rd) begin
        case (haddr)
          c_reg_maxpktsize: r_maxpktsize <= hdata_w;
          c_reg_router_en:  r_router_en  <= hdata_w[0];
          default: ;
        endcase
      end
      if (hen && !hwr_rd) r_hdata_r <= w_rd_mux;
    end
  end

endmodule

`default_nettype wire

// File: doc/yapp_router_n.md
# yapp_router_n

Parametrised YAPP packet router: accepts byte-serial YAPP packets on one input port, checks address, length and parity, and steers each packet into one of `NUM_CH` output channel FIFOs. It is configured and monitored over HBUS. It replaces the fixed 3-channel, 8-bit router under `hw_top` and uses the same YAPP, channel and HBUS interface conventions. New behaviour relative to the fixed router:
- HBUS read-back.
- Illegal-packet drop.
- Optional statistics counters.

## Interface
- `NUM_CH`, 3: number of output channels, 2..8.
- `DATA_W`, 8: byte width of the YAPP and channel data paths, minimum 8.
- `ADDR_W`, 2: width of the header address field, at least clog2(`NUM_CH`).
- `FIFO_DEPTH`, 16: entries per output FIFO, power of 2, minimum 4.
- `clock` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_data` in `DATA_W`: YAPP input byte.
- `in_data_vld` in 1: YAPP input byte valid.
- `in_suspend` out 1: router stalls the YAPP sender.
- `data` out `NUM_CH*DATA_W`: channel output bytes; channel i occupies slice [i*`DATA_W` +: `DATA_W`].
- `data_vld` out `NUM_CH`: per-channel output valid.
- `suspend` in `NUM_CH`: per-channel receiver stall.
- `haddr` in 8: HBUS register address.
- `hdata_w` in 8: HBUS write data.
- `hdata_r` out 8: HBUS read data.
- `hen` in 1: HBUS access enable.
- `hwr_rd` in 1: HBUS direction, 1 = write, 0 = read.
- `error` out 1: parity error pulse.

## Operation
- **Input acceptance.** An input byte is accepted on a cycle with `in_data_vld`=1 and `in_suspend`=0.
- **Header format.** The header is the first byte of a packet.
  - addr = header[`ADDR_W`-1:0].
  - len = header[`DATA_W`-1:`ADDR_W`], the payload byte count, 0 allowed.
  - The header is followed by len payload bytes, then 1 parity byte.
  - Parity rule: the XOR of header, payload and parity equals 0.
- **Legality check at the header.** The packet is legal when all of the following hold:
  - `router_en`=1;
  - addr < `NUM_CH`;
  - len ≤ `maxpktsize`.
  - A legal packet is written byte-for-byte, header and parity included, into FIFO[addr].
  - An illegal packet is consumed and discarded, and the drop counter increments.
- **FSM** (states IDLE, PAYLOAD, PARITY, DROP):
  - IDLE, header accepted and legal: go to PAYLOAD if len>0, else to PARITY. Load the remaining-byte counter with len.
  - IDLE, header accepted and illegal: go to DROP with counter = len+1, covering payload plus parity.
  - PAYLOAD: each accepted byte decrements the counter. At 1 → PARITY.
  - PARITY: the accepted byte is written to the FIFO. Then go to IDLE. If the running XOR including this byte is ≠0, assert `error`.
  - DROP: each accepted byte decrements the counter. At 1 → IDLE. No FIFO writes occur.
- **`in_suspend`** (combinational):
  - IDLE: OR of all FIFO-full flags.
  - PAYLOAD/PARITY: full flag of FIFO[addr].
  - DROP: 0.
- **Output channel i.**
  - `data_vld`[i] = FIFO[i] non-empty; `data` slice = FIFO head (first-word fall-through).
  - A byte pops when `data_vld`[i]=1 and `suspend`[i]=0.
  - A push and a pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
- **`router_en`** is sampled only at header acceptance. Clearing it mid-packet does not affect the packet in flight.
- **HBUS.**
  - Write: `hen`=1 and `hwr_rd`=1 writes `hdata_w` to register `haddr`.
  - Read: `hen`=1 and `hwr_rd`=0 loads `hdata_r` with register `haddr` on the next edge.
  - Unmapped address: reads return 0, writes are ignored.
- **Register map.**
  - 0x00 `maxpktsize`, RW, reset 0x3F.
  - 0x01 `router_en`, bit 0, RW, reset 0.
  - 0x02 drop count, RO, 8-bit saturating.
  - 0x03 parity error count, RO, 8-bit saturating.
  - Writes to 0x02 and 0x03 clear the counter.

## Timing
- **Reset values.** On `reset` low, asynchronously:
  - `in_suspend`=1, `data_vld`=0, `data`=0, `error`=0, `hdata_r`=0;
  - FSM in IDLE, all FIFOs empty, registers at their reset values.
  - After the deassertion edge, `in_suspend` follows its combinational rule. A partial packet in flight at reset is lost.
- **Latency.**
  - A byte accepted at edge N appears on `data`/`data_vld` at N+1 if the FIFO was empty.
  - `error` is high for exactly the one cycle after the parity byte is accepted.
  - `hdata_r` is valid the cycle after the read request and holds until the next read.
- **Full boundary.** With FIFO[addr] at `FIFO_DEPTH`-1 entries, the accepted byte fills it. `in_suspend` rises combinationally in the same cycle the full flag sets.
- **Counter saturation.** Counters saturate at 0xFF; no wrap.
- **Counter write collision.** A counter clear and an increment in the same cycle: the clear wins.

## Configuration
- **`YAPP_ROUTER_N_STATS_EN` defined:** drop and parity-error counters (0x02, 0x03) are implemented.
- **Undefined:**
  - the counters are absent;
  - reads of 0x02 and 0x03 return 0;
  - writes to them are ignored;
  - `error` behaviour is unchanged.

## Structure
- **Package `yapp_router_n_pkg`:**
  - FSM state enum;
  - register address constants (0x00–0x03);
  - reset values `MAXPKTSIZE_RST`=0x3F and `ROUTER_EN_RST`=0.
- **Sub-module `yapp_fifo`:**
  - parametrised width and depth;
  - synchronous FIFO, FWFT, with full/empty flags and asynchronous active-low reset;
  - instantiated `NUM_CH` times with a generate loop.

## Test plan
1. **Legal packet, channel 2.** Enable the router, send header 0x0E (len 3, addr 2), payload 0x11 0x22 0x33, correct parity → channel 2 emits the same 5 bytes; `error` stays 0; channels 0 and 1 stay idle.
2. **Bad parity.** Send the same packet with the parity byte XOR 0x01 → 5 bytes delivered; `error` is a 1-cycle pulse after the parity byte; reading 0x03 returns 0x01 (STATS_EN).
3. **Illegal packets dropped.** Send header addr 3 with `NUM_CH`=3, then a header with len 0x3F while `maxpktsize`=0x10 → no `data_vld` on any channel; `in_suspend`=0 throughout; drop count = 2.
4. **Backpressure.** With `FIFO_DEPTH`=4, hold `suspend`[0]=1 and send a len-6 packet to addr 0 → `in_suspend` rises after 4 bytes. Release `suspend`[0] → all 8 bytes are delivered in order.
5. **Reset mid-packet.** Pulse `reset` low mid-payload → outputs go to reset values immediately; `router_en` reads back 0 at 0x01.
6. **Disable mid-packet.** Write `router_en`=0 while a packet is in PAYLOAD → that packet completes; the next packet is dropped.
